cdb_arbiter: RTL and testbench

// - Shares the single result-broadcast bus (CDB) between the ALU/reservation station and the load & store buffer.
// - Feeds reorder-buffer value/ready writeback and RS/LSB operand wakeup.
// - Buffers each producer's completed results in a small FIFO.
// - Grants the bus round-robin and drives one registered broadcast per cycle.
// - Flushes all buffered results on a mispredict clear.

---
 rtl/cdb_arbiter_pkg.sv | 36 +++
 rtl/cdb_fifo.sv | 87 ++++++++
 rtl/cdb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared definitions for the common data bus (CDB). The reservation station,
//   load/store buffer and reorder buffer import this package so that every
//   consumer agrees on the bundle widths and the source-id encoding.
//
//   Contents
//     CDB_ROB_W       default reorder-buffer index width
//     CDB_FIFO_DEPTH  default per-source result FIFO depth (power of 2, >= 2)
//     CDB_VALUE_W     broadcast value width
//     cdb_src_e       source id carried with every broadcast
//     cdb_entry_t     one broadcast bundle (rob index + value)
//     other_src()     returns the opposite source, used by the round-robin
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int CDB_ROB_W      = 4;
   localparam int CDB_FIFO_DEPTH = 4;
   localparam int CDB_VALUE_W    = 32;
   localparam int CDB_ENTRY_W    = CDB_ROB_W + CDB_VALUE_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } cdb_src_e;

   typedef struct packed {
      logic [CDB_ROB_W-1:0]   rob_index;
      logic [CDB_VALUE_W-1:0] value;
   } cdb_entry_t;

   function automatic cdb_src_e other_src(input cdb_src_e src);
      return (src == SRC_ALU) ? SRC_LSB : SRC_ALU;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
//   Small synchronous FIFO holding completed results of one producer until
//   the CDB grants them. No fall-through: a full FIFO refuses a push even if
//   it is popped in the same cycle, and a pushed entry is visible at the head
//   only after the edge that wrote it.
//
//   Ports
//     clk_i    clock, rising edge
//     rst_ni   asynchronous active-low reset (empties the FIFO)
//     clear_i  synchronous flush; wins over push and pop in the same cycle
//     push_i   write data_i at the tail (ignored when full)
//     data_i   entry to write
//     pop_i    drop the head entry (ignored when empty)
//     data_o   head entry, valid whenever empty_o is low
//     empty_o  no entries held
//     full_o   DEPTH entries held
// -----------------------------------------------------------------------------
module cdb_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             push_en;
   logic             pop_en;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

   // Both qualifiers look only at the registered count, so a full FIFO
   // cannot make room for a same-cycle push by popping.
   assign push_en = push_i && !full_o && !clear_i;
   assign pop_en  = pop_i  && !empty_o && !clear_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap by overflow.
         if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single result-broadcast bus (CDB) between the ALU/reservation
//   station and the load/store buffer. Each producer's results queue in their
//   own cdb_fifo; every cycle one head entry is granted round-robin, popped,
//   and registered onto the cdb* outputs, which feed ROB writeback and
//   RS/LSB operand wakeup. A mispredict clear discards everything buffered.
//
//   Handshake (ALU and LSB inputs): a result transfers on the rising edge
//   where xValid && xReady. xReady depends only on registered FIFO occupancy
//   (and is held low during reset), never on xValid. The CDB side has no
//   back-pressure: cdbValid is high for exactly one cycle per entry.
//
//   Ports
//     clockIn       clock, rising edge
//     resetIn       asynchronous active-low reset
//     clear         synchronous mispredict flush
//     aluValid/aluReady/aluRobIndex/aluValue   ALU result input
//     lsbValid/lsbReady/lsbRobIndex/lsbValue   load result input
//     cdbValid/cdbRobIndex/cdbValue            registered broadcast
//     cdbSource     source of the last broadcast (0 = ALU, 1 = LSB), debug
// -----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_WIDTH  = CDB_ROB_W,
   parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
   input  logic                   clockIn,
   input  logic                   resetIn,
   input  logic                   clear,
   input  logic                   aluValid,
   output logic                   aluReady,
   input  logic [ROB_WIDTH-1:0]   aluRobIndex,
   input  logic [CDB_VALUE_W-1:0] aluValue,
   input  logic                   lsbValid,
   output logic                   lsbReady,
   input  logic [ROB_WIDTH-1:0]   lsbRobIndex,
   input  logic [CDB_VALUE_W-1:0] lsbValue,
   output logic                   cdbValid,
   output logic [ROB_WIDTH-1:0]   cdbRobIndex,
   output logic [CDB_VALUE_W-1:0] cdbValue,
   output logic                   cdbSource
);

   localparam int ENT_W = ROB_WIDTH + CDB_VALUE_W;

   // ---------------------------------------------------------------- FIFOs
   logic [ENT_W-1:0] alu_head, lsb_head;
   logic             alu_empty, lsb_empty;
   logic             alu_full, lsb_full;
   logic             alu_pop, lsb_pop;

   cdb_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_alu_fifo (
      .clk_i   (clockIn),
      .rst_ni  (resetIn),
      .clear_i (clear),
      .push_i  (aluValid),
      .data_i  ({aluRobIndex, aluValue}),
      .pop_i   (alu_pop),
      .data_o  (alu_head),
      .empty_o (alu_empty),
      .full_o  (alu_full)
   );

   cdb_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_lsb_fifo (
      .clk_i   (clockIn),
      .rst_ni  (resetIn),
      .clear_i (clear),
      .push_i  (lsbValid),
      .data_i  ({lsbRobIndex, lsbValue}),
      .pop_i   (lsb_pop),
      .data_o  (lsb_head),
      .empty_o (lsb_empty),
      .full_o  (lsb_full)
   );

   // Ready is forced low while reset is asserted, independent of the clock.
   assign aluReady = resetIn && !alu_full;
   assign lsbReady = resetIn && !lsb_full;

   // ------------------------------------------------------ priority pointer
   cdb_src_e         prio_q, prio_d;
   logic             grant_valid;
   cdb_src_e         grant_src;
   logic [ENT_W-1:0] grant_entry;

   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) prio_q <= SRC_ALU;
      else          prio_q <= prio_d;
   end

   // Grant from registered FIFO state. Whichever source wins, the pointer
   // then names the other one, so a waiting head is passed over at most once.
   always_comb begin
      grant_valid = 1'b0;
      grant_src   = SRC_ALU;
      prio_d      = prio_q;
      if (!alu_empty && !lsb_empty) begin
         grant_valid = 1'b1;
         grant_src   = prio_q;
      end else if (!alu_empty) begin
         grant_valid = 1'b1;
         grant_src   = SRC_ALU;
      end else if (!lsb_empty) begin
         grant_valid = 1'b1;
         grant_src   = SRC_LSB;
      end
      if (grant_valid) prio_d = other_src(grant_src);
      if (clear) begin
         grant_valid = 1'b0;
         prio_d      = SRC_ALU;
      end
   end

   assign alu_pop     = grant_valid && (grant_src == SRC_ALU);
   assign lsb_pop     = grant_valid && (grant_src == SRC_LSB);
   assign grant_entry = (grant_src == SRC_LSB) ? lsb_head : alu_head;

   // ------------------------------------------------------ output register
   logic                   cdb_valid_q, cdb_valid_d;
   logic [ROB_WIDTH-1:0]   cdb_rob_q,   cdb_rob_d;
   logic [CDB_VALUE_W-1:0] cdb_value_q, cdb_value_d;
   cdb_src_e               cdb_src_q,   cdb_src_d;

   // Index, value and source hold their last broadcast on idle cycles.
   always_comb begin
      cdb_valid_d = grant_valid;
      cdb_rob_d   = cdb_rob_q;
      cdb_value_d = cdb_value_q;
      cdb_src_d   = cdb_src_q;
      if (grant_valid) begin
         cdb_rob_d   = grant_entry[ENT_W-1 -: ROB_WIDTH];
         cdb_value_d = grant_entry[CDB_VALUE_W-1:0];
         cdb_src_d   = grant_src;
      end
   end

   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         cdb_valid_q <= 1'b0;
         cdb_rob_q   <= '0;
         cdb_value_q <= '0;
         cdb_src_q   <= SRC_ALU;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_rob_q   <= cdb_rob_d;
         cdb_value_q <= cdb_value_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign cdbValid    = cdb_valid_q;
   assign cdbRobIndex = cdb_rob_q;
   assign cdbValue    = cdb_value_q;
   assign cdbSource   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed and randomized stimulus for cdb_arbiter. A queue-based model of
//   the two result buffers and the round-robin rule predicts every broadcast
//   and every ready flag.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int RW    = 4;
   localparam int DEPTH = 4;

   logic          clockIn = 1'b0;
   logic          resetIn;
   logic          clear;
   logic          aluValid, lsbValid;
   logic          aluReady, lsbReady;
   logic [RW-1:0] aluRobIndex, lsbRobIndex;
   logic [31:0]   aluValue, lsbValue;
   logic          cdbValid;
   logic [RW-1:0] cdbRobIndex;
   logic [31:0]   cdbValue;
   logic          cdbSource;

   cdb_arbiter #(
      .ROB_WIDTH  (RW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clockIn     (clockIn),
      .resetIn     (resetIn),
      .clear       (clear),
      .aluValid    (aluValid),
      .aluReady    (aluReady),
      .aluRobIndex (aluRobIndex),
      .aluValue    (aluValue),
      .lsbValid    (lsbValid),
      .lsbReady    (lsbReady),
      .lsbRobIndex (lsbRobIndex),
      .lsbValue    (lsbValue),
      .cdbValid    (cdbValid),
      .cdbRobIndex (cdbRobIndex),
      .cdbValue    (cdbValue),
      .cdbSource   (cdbSource)
   );

   // ------------------------------------------------------ clock
   always #5 clockIn = ~clockIn;

   // ------------------------------------------------------ model state
   logic [RW+31:0] alu_q[$];
   logic [RW+31:0] lsb_q[$];
   logic           m_prio;       // source that wins when both are waiting
   logic           m_valid;
   logic [RW+31:0] m_ent;
   logic           m_src;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [RW+31:0] rnd_ent();
      logic [RW+31:0] e;
      e[RW+31:32] = RW'($urandom);
      e[31:0]     = $urandom;
      return e;
   endfunction

   // Assert reset mid-cycle, check the immediate effect, release mid-cycle.
   task automatic do_reset();
      resetIn  = 1'b0;
      clear    = 1'b0;
      aluValid = 1'b0;
      lsbValid = 1'b0;
      #2;
      alu_q.delete();
      lsb_q.delete();
      m_prio  = 1'b0;
      m_valid = 1'b0;
      m_ent   = '0;
      m_src   = 1'b0;
      chk("rst_cdb_valid", 64'(cdbValid), 64'd0);
      chk("rst_cdb_rob", 64'(cdbRobIndex), 64'd0);
      chk("rst_cdb_value", 64'(cdbValue), 64'd0);
      chk("rst_cdb_source", 64'(cdbSource), 64'd0);
      chk("rst_alu_ready", 64'(aluReady), 64'd0);
      chk("rst_lsb_ready", 64'(lsbReady), 64'd0);
      @(posedge clockIn);
      #4;
      chk("rst_hold_valid", 64'(cdbValid), 64'd0);
      resetIn = 1'b1;
      #1;
   endtask

   // One clock cycle: drive inputs, check ready, advance the model across the
   // edge, then check the registered broadcast.
   task automatic tick(input logic av, input logic [RW+31:0] ad,
                       input logic bv, input logic [RW+31:0] bd,
                       input logic clr);
      logic a_rdy, b_rdy, have, g;
      aluValid    = av;
      aluRobIndex = ad[RW+31:32];
      aluValue    = ad[31:0];
      lsbValid    = bv;
      lsbRobIndex = bd[RW+31:32];
      lsbValue    = bd[31:0];
      clear       = clr;
      #1;
      a_rdy = (alu_q.size() != DEPTH);
      b_rdy = (lsb_q.size() != DEPTH);
      chk("alu_ready", 64'(aluReady), 64'(a_rdy));
      chk("lsb_ready", 64'(lsbReady), 64'(b_rdy));
      if (clr) begin
         alu_q.delete();
         lsb_q.delete();
         m_valid = 1'b0;
         m_prio  = 1'b0;
      end else begin
         have = 1'b1;
         g    = 1'b0;
         if (alu_q.size() != 0 && lsb_q.size() != 0) g = m_prio;
         else if (alu_q.size() != 0)                  g = 1'b0;
         else if (lsb_q.size() != 0)                  g = 1'b1;
         else                                         have = 1'b0;
         m_valid = have;
         if (have) begin
            m_ent  = g ? lsb_q.pop_front() : alu_q.pop_front();
            m_src  = g;
            m_prio = ~g;
         end
         if (av && a_rdy) alu_q.push_back(ad);
         if (bv && b_rdy) lsb_q.push_back(bd);
      end
      @(posedge clockIn);
      #1;
      chk("cdb_valid", 64'(cdbValid), 64'(m_valid));
      chk("cdb_rob", 64'(cdbRobIndex), 64'(m_ent[RW+31:32]));
      chk("cdb_value", 64'(cdbValue), 64'(m_ent[31:0]));
      if (m_valid) chk("cdb_source", 64'(cdbSource), 64'(m_src));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   // ------------------------------------------------------ stimulus
   initial begin
      logic [RW+31:0] e0, e1;
      aluRobIndex = '0;
      aluValue    = '0;
      lsbRobIndex = '0;
      lsbValue    = '0;
      do_reset();

      // single ALU result: visible after the second edge only
      e0 = {4'd3, 32'hDEADBEEF};
      tick(1'b1, e0, 1'b0, '0, 1'b0);
      idle(3);

      // same-cycle ALU and LSB from reset: ALU first, then LSB
      do_reset();
      tick(1'b1, {4'd1, 32'h11}, 1'b1, {4'd2, 32'h22}, 1'b0);
      idle(3);

      // both sources push every cycle for 12 cycles, then drain
      do_reset();
      for (int i = 0; i < 12; i++) tick(1'b1, rnd_ent(), 1'b1, rnd_ent(), 1'b0);
      idle(10);

      // clear with 3 ALU and 2 LSB buffered plus an ALU push that cycle
      do_reset();
      for (int i = 0; i < 5; i++) tick(1'b1, rnd_ent(), 1'b1, rnd_ent(), 1'b0);
      idle(1);
      tick(1'b1, rnd_ent(), 1'b0, '0, 1'b0);
      chk("pre_clear_alu_depth", 64'(alu_q.size()), 64'd3);
      chk("pre_clear_lsb_depth", 64'(lsb_q.size()), 64'd2);
      tick(1'b1, rnd_ent(), 1'b0, '0, 1'b1);
      idle(6);

      // reset mid-operation with both buffers holding two entries
      do_reset();
      for (int i = 0; i < 3; i++) tick(1'b1, rnd_ent(), 1'b1, rnd_ent(), 1'b0);
      do_reset();
      idle(4);

      // LSB-only sequence long enough to wrap the pointers
      do_reset();
      for (int i = 0; i < 10; i++) begin
         e1 = {RW'(i), $urandom};
         tick(1'b0, '0, 1'b1, e1, 1'b0);
      end
      idle(3);

      // randomized traffic with occasional clears
      do_reset();
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 1)), rnd_ent(),
              1'($urandom_range(0, 1)), rnd_ent(),
              ($urandom_range(0, 24) == 0));
      end
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
